ysyx_24110015_axi_uart: RTL and testbench



---
 rtl/ysyx_24110015_axi_uart_pkg.sv | 34 +++
 rtl/ysyx_24110015_axi_uart_if.sv | 32 +++
 rtl/ysyx_24110015_axi_uart_fifo.sv | 63 ++++++
 rtl/ysyx_24110015_axi_uart.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ysyx_24110015_axi_uart.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24110015_axi_uart_pkg.sv
// Shared definitions for the AXI4-Lite console UART.
// Holds the register offsets, AXI response codes, the three FSM state
// encodings and two small decode helpers used by the top level.
package ysyx_24110015_uart_pkg;

    localparam logic [3:0] REG_TXDATA = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_DIV    = 4'h8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_RESP}                           r_state_e;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP}          t_state_e;

    // 0xC is unmapped and anything not word aligned is rejected.
    function automatic logic addr_invalid(input logic [3:0] addr);
        return (addr[1:0] != 2'b00) || (addr == 4'hC);
    endfunction

    function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_24110015_axi_uart_if.sv
// AXI4-Lite channel bundle: 32-bit address/data, 4-bit write strobe,
// 2-bit responses. slave modport for the UART, master modport for the
// requester side.
interface axi_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ysyx_24110015_axi_uart_fifo.sv
// Synchronous FIFO used as the UART TX queue.
// Ports: clk, rst (sync, active high), push/din, pop/dout (dout shows the
// head entry combinationally), full, empty, count (0..DEPTH).
// A push while full is dropped even if a pop happens in the same cycle.
module ysyx_24110015_SyncFifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ysyx_24110015_axi_uart.sv
// AXI4-Lite console UART (transmit only) with TX FIFO and 8N1 output.
// Ports: clk, rst (sync, active high), axi (AXI4-Lite slave), uart_tx
// (serial out, idle high).
// Registers: 0x0 TXDATA (W push), 0x4 STATUS (R), 0x8 DIV (R/W).
//
// state       | meaning
// W_IDLE      | ready for AW and W
// W_WAIT_DATA | AW taken, waiting for W
// W_WAIT_ADDR | W taken, waiting for AW
// W_RESP      | holding bvalid/bresp until bready
// R_IDLE      | ready for AR
// R_RESP      | holding rvalid/rdata/rresp until rready
// T_IDLE      | line idle high, waiting for FIFO data
// T_START     | start bit (0)
// T_DATA      | 8 data bits, LSB first
// T_STOP      | stop bit (1)
module ysyx_24110015_axi_uart
    import ysyx_24110015_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int DIV_RESET  = 16
) (
    input  logic clk,
    input  logic rst,
    axi_if.slave axi,
    output logic uart_tx
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    t_state_e t_state_q, t_state_d;

    logic [3:0]           aw_addr_q, aw_addr_d;
    logic [31:0]          w_data_q, w_data_d;
    logic [3:0]           w_strb_q, w_strb_d;
    logic [1:0]           bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [DIV_WIDTH-1:0] div_q, div_d, frame_div_q, frame_div_d, baud_cnt_q, baud_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;

    logic                 wr_fire, start_frame, tx_busy, baud_tc;
    logic [3:0]           wr_addr;
    logic [31:0]          wr_data, merged_div;
    logic [3:0]           wr_strb;
    logic [DIV_WIDTH-1:0] div_eff;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]           fifo_dout;
    logic [CNT_W-1:0]     fifo_count;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^{axi.awaddr[31:4], axi.araddr[31:4]};

    ysyx_24110015_SyncFifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(fifo_push), .din(wr_data[7:0]), .pop(fifo_pop),
        .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
    );

    assign tx_busy    = (t_state_q != T_IDLE);
    assign div_eff    = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
    assign baud_tc    = (baud_cnt_q == '0);
    assign merged_div = merge_strb(32'(div_q), wr_data, wr_strb);
    assign axi.bresp  = bresp_q;
    assign axi.rdata  = rdata_q;
    assign axi.rresp  = rresp_q;

    // Write channel; the register effect is applied on the final handshake.
    always_comb begin
        w_state_d   = w_state_q;
        aw_addr_d   = aw_addr_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        bresp_d     = bresp_q;
        div_d       = div_q;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        wr_fire     = 1'b0;
        fifo_push   = 1'b0;
        wr_addr     = aw_addr_q;
        wr_data     = w_data_q;
        wr_strb     = w_strb_q;
        case (w_state_q)
            W_IDLE: begin
                axi.awready = 1'b1;
                axi.wready  = 1'b1;
                if (axi.awvalid && axi.wvalid) begin
                    wr_fire   = 1'b1;
                    wr_addr   = axi.awaddr[3:0];
                    wr_data   = axi.wdata;
                    wr_strb   = axi.wstrb;
                    w_state_d = W_RESP;
                end else if (axi.awvalid) begin
                    aw_addr_d = axi.awaddr[3:0];
                    w_state_d = W_WAIT_DATA;
                end else if (axi.wvalid) begin
                    w_data_d  = axi.wdata;
                    w_strb_d  = axi.wstrb;
                    w_state_d = W_WAIT_ADDR;
                end
            end
            W_WAIT_DATA: begin
                axi.wready = 1'b1;
                if (axi.wvalid) begin
                    wr_fire   = 1'b1;
                    wr_data   = axi.wdata;
                    wr_strb   = axi.wstrb;
                    w_state_d = W_RESP;
                end
            end
            W_WAIT_ADDR: begin
                axi.awready = 1'b1;
                if (axi.awvalid) begin
                    wr_fire   = 1'b1;
                    wr_addr   = axi.awaddr[3:0];
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                axi.bvalid = 1'b1;
                if (axi.bready) w_state_d = W_IDLE;
            end
        endcase

        if (wr_fire) begin
            bresp_d = RESP_OKAY;
            if (addr_invalid(wr_addr)) begin
                bresp_d = RESP_DECERR;
            end else if (wr_addr == REG_TXDATA && wr_strb[0]) begin
                if (fifo_full) bresp_d = RESP_SLVERR;
                else           fifo_push = 1'b1;
            end else if (wr_addr == REG_DIV) begin
                div_d = merged_div[DIV_WIDTH-1:0];
            end
        end
    end

    // Read channel; response data is frozen at the AR handshake.
    always_comb begin
        r_state_d   = r_state_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                axi.arready = 1'b1;
                if (axi.arvalid) begin
                    r_state_d = R_RESP;
                    rdata_d   = '0;
                    rresp_d   = RESP_OKAY;
                    if (addr_invalid(axi.araddr[3:0])) begin
                        rresp_d = RESP_DECERR;
                    end else if (axi.araddr[3:0] == REG_STATUS) begin
                        rdata_d = {16'h0, 8'(fifo_count), 5'h0, tx_busy, fifo_empty, fifo_full};
                    end else if (axi.araddr[3:0] == REG_DIV) begin
                        rdata_d = 32'(div_q);
                    end
                end
            end
            R_RESP: begin
                axi.rvalid = 1'b1;
                if (axi.rready) r_state_d = R_IDLE;
            end
        endcase
    end

    // TX engine; baud_cnt counts down to 0 then the bit ends.
    always_comb begin
        t_state_d   = t_state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        baud_cnt_d  = baud_tc ? frame_div_q - DIV_WIDTH'(1) : baud_cnt_q - DIV_WIDTH'(1);
        frame_div_d = frame_div_q;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;
        case (t_state_q)
            T_IDLE: begin
                baud_cnt_d  = baud_cnt_q;
                start_frame = !fifo_empty;
            end
            T_START: begin
                if (baud_tc) begin
                    t_state_d = T_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            T_DATA: begin
                if (baud_tc) begin
                    if (bit_idx_q == 3'd7) begin
                        t_state_d = T_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            T_STOP: begin
                if (baud_tc) begin
                    if (!fifo_empty) start_frame = 1'b1;
                    else             t_state_d   = T_IDLE;
                end
            end
        endcase
        if (start_frame) begin
            t_state_d   = T_START;
            fifo_pop    = 1'b1;
            shift_d     = fifo_dout;
            frame_div_d = div_eff;
            baud_cnt_d  = div_eff - DIV_WIDTH'(1);
        end
    end

    always_comb begin
        case (t_state_q)
            T_START: uart_tx = 1'b0;
            T_DATA:  uart_tx = shift_q[0];
            default: uart_tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            t_state_q   <= T_IDLE;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            bresp_q     <= RESP_OKAY;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
            div_q       <= DIV_WIDTH'(DIV_RESET);
            frame_div_q <= DIV_WIDTH'(1);
            baud_cnt_q  <= '0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            t_state_q   <= t_state_d;
            aw_addr_q   <= aw_addr_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            bresp_q     <= bresp_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            div_q       <= div_d;
            frame_div_q <= frame_div_d;
            baud_cnt_q  <= baud_cnt_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
        end
    end

`ifdef YSYX_UART_PRINT
    // Console echo for simulation builds that define YSYX_UART_PRINT.
    always_ff @(posedge clk) begin
        if (fifo_push) $write("%c", wr_data[7:0]);
    end
`endif

endmodule

// File: tb/tb_ysyx_24110015_axi_uart.sv
module tb_ysyx_24110015_axi_uart;
    import ysyx_24110015_uart_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic uart_tx;
    int   n_checks = 0;
    int   n_fail   = 0;

    axi_if axi();

    ysyx_24110015_axi_uart #(.FIFO_DEPTH(16), .DIV_WIDTH(16), .DIV_RESET(16)) dut (
        .clk(clk), .rst(rst), .axi(axi), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] r);
        int   n;
        logic aw_hs, w_hs, got;
        axi.awaddr = a; axi.awvalid = 1'b1;
        axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
        n = 0;
        while ((axi.awvalid || axi.wvalid) && n < 20) begin
            @(negedge clk);
            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            @(posedge clk); #1;
            if (aw_hs) axi.awvalid = 1'b0;
            if (w_hs)  axi.wvalid  = 1'b0;
            n++;
        end
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b1;
        n = 0; got = 1'b0; r = 2'bxx;
        do begin
            @(negedge clk);
            got = axi.bvalid;
            r   = axi.bresp;
            @(posedge clk); #1;
            n++;
        end while (!got && n < 20);
        axi.bready = 1'b0;
        chk("wr_bvalid_seen", 32'(got), 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int   n;
        logic got;
        axi.araddr = a; axi.arvalid = 1'b1;
        n = 0; got = 1'b0;
        do begin
            @(negedge clk);
            got = axi.arready;
            @(posedge clk); #1;
            n++;
        end while (!got && n < 20);
        axi.arvalid = 1'b0; axi.rready = 1'b1;
        n = 0; got = 1'b0; d = 'x; r = 2'bxx;
        do begin
            @(negedge clk);
            got = axi.rvalid;
            d   = axi.rdata;
            r   = axi.rresp;
            @(posedge clk); #1;
            n++;
        end while (!got && n < 20);
        axi.rready = 1'b0;
        chk("rd_rvalid_seen", 32'(got), 32'd1);
    endtask

    // Samples every cycle of a frame starting at the next negedge.
    task automatic check_frame(input string tag, input logic [7:0] b, input int div);
        logic [79:0] obs, exp;
        logic        bitv;
        int          idx;
        obs = '0; exp = '0; idx = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      bitv = 1'b0;
            else if (k == 9) bitv = 1'b1;
            else             bitv = b[k-1];
            for (int c = 0; c < div; c++) begin
                exp[idx] = bitv;
                @(negedge clk);
                obs[idx] = uart_tx;
                idx++;
            end
        end
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits for a start bit then samples each later bit div cycles apart.
    task automatic rx_byte(input int div, input int limit, output logic [7:0] b, output logic stop_bit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (uart_tx !== 1'b0 && n < limit);
        chk("rx_start_bit", 32'(uart_tx), 32'd0);
        for (int k = 0; k < 8; k++) begin
            repeat (div) @(negedge clk);
            b[k] = uart_tx;
        end
        repeat (div) @(negedge clk);
        stop_bit = uart_tx;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        logic [7:0]  rb;
        logic        sb;
        int          run, n;

        rst = 1'b1;
        axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
        axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("reset_flags", 32'({uart_tx, axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}), 32'h3C);
        chk("reset_resp_data", {axi.rdata[29:0], axi.bresp ^ axi.rresp}, 32'h0);
        @(posedge clk); #1;
        axi_read(32'h8, rd, rs);
        chk("div_reset", rd, 32'h10);
        chk("div_reset_resp", 32'(rs), 32'(RESP_OKAY));
        axi_read(32'h4, rd, rs);
        chk("status_reset", rd, 32'h2);

        // W three cycles ahead of AW, bready held low for five cycles
        axi.awaddr = 32'h0; axi.wdata = 32'h41; axi.wstrb = 4'h1; axi.wvalid = 1'b1;
        @(negedge clk);
        chk("w_first_wready", 32'(axi.wready), 32'd1);
        @(posedge clk); #1;
        axi.wvalid = 1'b0; axi.wdata = 32'hFF;
        @(negedge clk);
        chk("wait_addr_ready", 32'({axi.awready, axi.wready, axi.bvalid}), 32'b100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        axi.awvalid = 1'b1;
        @(negedge clk);
        chk("aw_late_ready", 32'({axi.awready, axi.wready, axi.bvalid}), 32'b100);
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("b_hold", 32'({axi.bvalid, axi.bresp}), 32'b100);
        end
        axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.bready = 1'b0;
        @(negedge clk);
        chk("b_released", 32'(axi.bvalid), 32'd0);
        rx_byte(16, 40, rb, sb);
        chk("rx_split_byte", 32'(rb), 32'h41);
        chk("rx_split_stop", 32'(sb), 32'd1);
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        axi_read(32'h4, rd, rs);
        chk("status_single_push", rd, 32'h2);

        // DIV=4 frame of 0x55
        axi_write(32'h8, 32'h4, 4'hF, rs);
        chk("div4_resp", 32'(rs), 32'(RESP_OKAY));
        axi_write(32'h0, 32'h55, 4'h1, rs);
        chk("tx55_resp", 32'(rs), 32'(RESP_OKAY));
        chk("tx55_latency", 32'(uart_tx), 32'd0);
        check_frame("frame_55_div4", 8'h55, 4);
        @(negedge clk);
        chk("idle_after_55", 32'(uart_tx), 32'd1);
        @(posedge clk); #1;
        axi_read(32'h4, rd, rs);
        chk("status_after_55", rd, 32'h2);

        // DIV byte strobes, then DIV=0 acting as 1
        axi_write(32'h8, 32'h0000_AB00, 4'h2, rs);
        axi_read(32'h8, rd, rs);
        chk("div_strobe", rd, 32'hAB04);
        axi_write(32'h8, 32'hFFFF_0000, 4'hF, rs);
        axi_read(32'h8, rd, rs);
        chk("div_zero", rd, 32'h0);
        axi_write(32'h0, 32'h3C, 4'h1, rs);
        chk("tx3c_latency", 32'(uart_tx), 32'd0);
        check_frame("frame_3c_div0", 8'h3C, 1);

        // decode errors
        axi_read(32'h6, rd, rs);
        chk("rd_unaligned_resp", 32'(rs), 32'(RESP_DECERR));
        chk("rd_unaligned_data", rd, 32'h0);
        axi_read(32'hC, rd, rs);
        chk("rd_0c_resp", 32'(rs), 32'(RESP_DECERR));
        axi_write(32'hC, 32'h1, 4'hF, rs);
        chk("wr_0c_resp", 32'(rs), 32'(RESP_DECERR));
        axi_write(32'h2, 32'h41, 4'hF, rs);
        chk("wr_unaligned_resp", 32'(rs), 32'(RESP_DECERR));
        axi_read(32'h8, rd, rs);
        chk("div_after_decerr", rd, 32'h0);
        axi_read(32'h4, rd, rs);
        chk("status_after_decerr", rd, 32'h2);

        // fill FIFO behind a slow lead byte
        axi_write(32'h8, 32'd1000, 4'hF, rs);
        axi_write(32'h0, 32'h00, 4'h1, rs);
        for (int i = 0; i < 16; i++) begin
            axi_write(32'h0, 32'(8'h30 + i), 4'h1, rs);
            chk("fill_resp", 32'(rs), 32'(RESP_OKAY));
        end
        axi_read(32'h4, rd, rs);
        chk("status_full", rd, 32'h0000_1005);
        axi_write(32'h0, 32'hEE, 4'h1, rs);
        chk("overflow_resp", 32'(rs), 32'(RESP_SLVERR));
        axi_write(32'h0, 32'hEF, 4'h2, rs);
        chk("full_nostrb_resp", 32'(rs), 32'(RESP_OKAY));
        axi_read(32'h4, rd, rs);
        chk("status_still_full", rd, 32'h0000_1005);
        axi_write(32'h8, 32'd2, 4'hF, rs);
        run = 0; n = 0;
        while (run < 900 && n < 15000) begin
            @(negedge clk);
            run = (uart_tx === 1'b1) ? run + 1 : 0;
            n++;
        end
        chk("lead_stop_seen", 32'(run >= 900), 32'd1);
        for (int i = 0; i < 16; i++) begin
            rx_byte(2, 1200, rb, sb);
            chk("drain_byte", 32'({sb, rb}), 32'({1'b1, 8'h30 + 8'(i)}));
        end
        repeat (30) @(negedge clk);
        @(posedge clk); #1;
        axi_read(32'h4, rd, rs);
        chk("status_drained", rd, 32'h2);

        // reset mid-frame with three bytes queued
        axi_write(32'h8, 32'd50, 4'hF, rs);
        for (int i = 0; i < 4; i++) axi_write(32'h0, 32'(8'h61 + i), 4'h1, rs);
        axi_read(32'h4, rd, rs);
        chk("status_queued", rd, 32'h0000_0304);
        chk("midframe_low", 32'(uart_tx), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_tx_high", 32'({uart_tx, axi.bvalid, axi.rvalid}), 32'b100);
        rst = 1'b0;
        axi_read(32'h4, rd, rs);
        chk("status_after_rst", rd, 32'h2);
        axi_read(32'h8, rd, rs);
        chk("div_after_rst", rd, 32'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
